zeroriscy_htif_mon: RTL and testbench

- Synthesizable host-interface monitor on the zero-riscy core data port, tapped in parallel next to the dp_sram in zeroriscy_sim_top.
- Decodes stores to a parametrised set of tohost addresses and issues a pass / fail / timeout verdict.
- Buffers console putchar bytes in a FIFO with ready/valid drain.
- Replaces ad-hoc bench monitors, so FPGA builds and simulation share one verdict/console path.

---
 rtl/zeroriscy_htif_pkg.sv | 18 +
 rtl/zeroriscy_htif_con_fifo.sv | 66 ++++++
 rtl/zeroriscy_htif_mon.sv | 137 +++++++++++++
 tb/tb_zeroriscy_htif_mon.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_htif_pkg.sv
// Shared types and default addresses for the zero-riscy host-interface monitor.
package zeroriscy_htif_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } htif_state_e;

  localparam logic [31:0] HTIF_TOHOST0 = 32'h8000_1000;
  localparam logic [31:0] HTIF_TOHOST1 = 32'h8000_3000;
  localparam logic [31:0] HTIF_TOHOST2 = 32'h8017_fffc;
  localparam logic [31:0] HTIF_CONSOLE = 32'h9a10_0000;

  localparam int HTIF_FAIL_W = 31;

endpackage

// File: rtl/zeroriscy_htif_con_fifo.sv
// Console byte FIFO with a registered head, wrap-bit pointers and a sticky drop flag.
module zeroriscy_htif_con_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty, full, do_pop, do_push;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  // The head register is refreshed from the slot rd_ptr_d will point at; when that
  // slot is being written this very edge, the incoming byte is taken instead.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    ovf_d    = ovf_q | (push_i & full & ~do_pop);
    head_d   = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = din_i;
      else                                                   head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o     = head_q;
  assign valid_o    = ~empty;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/zeroriscy_htif_mon.sv
// Passive tohost verdict / console monitor on the zero-riscy data port.
// Define ZERORISCY_HTIF_MON_TRACE_EN to add simulation console echo and verdict messages.
module zeroriscy_htif_mon
  import zeroriscy_htif_pkg::*;
#(
  parameter int                      NUM_TOHOST   = 3,
  parameter logic [NUM_TOHOST*32-1:0] TOHOST_ADDRS = {HTIF_TOHOST2, HTIF_TOHOST1, HTIF_TOHOST0},
  parameter logic [31:0]             CONSOLE_ADDR = HTIF_CONSOLE,
  parameter int                      CON_DEPTH    = 16,
  parameter int                      CYCLE_W      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [3:0]             data_be_i,
  input  logic [31:0]            data_addr_i,
  input  logic [31:0]            data_wdata_i,
  input  logic [CYCLE_W-1:0]     max_cycles_i,
  output logic                   con_valid_o,
  output logic [7:0]             con_data_o,
  input  logic                   con_ready_i,
  output logic                   con_overflow_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [HTIF_FAIL_W-1:0] fail_code_o,
  output logic [CYCLE_W-1:0]     cycle_count_o
);

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (&v) ? v : v + CYCLE_W'(1);
  endfunction

  htif_state_e            state_q, state_d;
  logic [CYCLE_W-1:0]     cnt_q, cnt_d;
  logic                   hit_p1_q, hit_p1_d;
  logic [31:0]            wdata_p1_q;
  logic [HTIF_FAIL_W-1:0] fail_code_q, fail_code_d;

  logic store, tohost_hit, con_push, con_pop, timeout_cond;
  logic unused_be;

  assign store     = data_req_i & data_we_i;
  assign con_push  = store & (data_addr_i == CONSOLE_ADDR) & data_be_i[0];
  assign con_pop   = con_valid_o & con_ready_i;
  assign unused_be = ^data_be_i[3:1];

  always_comb begin
    tohost_hit = 1'b0;
    for (int i = 0; i < NUM_TOHOST; i++) begin
      if (data_addr_i == TOHOST_ADDRS[i*32 +: 32]) tohost_hit = 1'b1;
    end
  end

  assign hit_p1_d     = store & tohost_hit;
  assign timeout_cond = (max_cycles_i != '0) && (cnt_q > max_cycles_i);

  // Stage 1 -> stage 2 boundary: registered tohost hit and write data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      hit_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_p1_q <= hit_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    wdata_p1_q  <= data_wdata_i;
    fail_code_q <= fail_code_d;
  end

  // Tohost verdict takes precedence over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    cnt_d       = (state_q == RUN) ? sat_inc(cnt_q) : cnt_q;
    if (state_q == RUN) begin
      if (hit_p1_q && (wdata_p1_q == 32'd1)) begin
        state_d = PASS;
      end else if (hit_p1_q && (wdata_p1_q != 32'd0)) begin
        state_d     = FAIL;
        fail_code_d = wdata_p1_q[31:1];
      end else if (timeout_cond) begin
        state_d = TIMEOUT;
      end
    end
  end

  always_comb begin
    done_o        = (state_q != RUN);
    pass_o        = (state_q == PASS);
    timeout_o     = (state_q == TIMEOUT);
    fail_code_o   = (state_q == FAIL) ? fail_code_q : '0;
    cycle_count_o = cnt_q;
  end

  zeroriscy_htif_con_fifo #(
    .DEPTH (CON_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (con_push),
    .din_i      (data_wdata_i[7:0]),
    .pop_i      (con_pop),
    .dout_o     (con_data_o),
    .valid_o    (con_valid_o),
    .overflow_o (con_overflow_o)
  );

`ifdef ZERORISCY_HTIF_MON_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (con_pop) $write("%s", con_data_o);
      if (state_q == RUN) begin
        if (state_d == PASS) begin
          $display("*** PASSED *** after %d simulation cycles", cnt_d);
          $finish;
        end else if (state_d == FAIL) begin
          $display("*** FAILED *** (tohost = %d)", wdata_p1_q);
          $finish;
        end else if (state_d == TIMEOUT) begin
          $display("*** FAILED *** (timeout)");
          $finish;
        end
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_zeroriscy_htif_mon.sv
// Scoreboard bench for zeroriscy_htif_mon: verdict and console expectations are queued, monitors compare.
module tb_zeroriscy_htif_mon;

  localparam logic [31:0] CON = 32'h9a10_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic [63:0] max_cycles = '0;
  logic        con_ready = 1'b0;

  logic        con_valid, con_overflow, done, pass, tmo;
  logic [7:0]  con_data;
  logic [30:0] fail_code;
  logic [63:0] cycle_count;

  always #5 clk = ~clk;

  zeroriscy_htif_mon dut (
    .clk            (clk),
    .reset          (reset),
    .data_req_i     (req),
    .data_we_i      (we),
    .data_be_i      (be),
    .data_addr_i    (addr),
    .data_wdata_i   (wdata),
    .max_cycles_i   (max_cycles),
    .con_valid_o    (con_valid),
    .con_data_o     (con_data),
    .con_ready_i    (con_ready),
    .con_overflow_o (con_overflow),
    .done_o         (done),
    .pass_o         (pass),
    .timeout_o      (tmo),
    .fail_code_o    (fail_code),
    .cycle_count_o  (cycle_count)
  );

  typedef struct {
    logic        p;
    logic        t;
    logic [30:0] code;
    logic [63:0] cnt;
    int          edge_n;
  } verdict_t;

  typedef struct {
    logic [7:0] b;
    int         edge_n;
  } con_t;

  verdict_t vq[$];
  con_t     cq[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  bit       done_seen = 1'b0;

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output presented with nothing expected", name);
  endtask

  task automatic exp_verdict(input logic p, input logic t, input logic [30:0] code,
                             input logic [63:0] cnt, input int e);
    verdict_t v;
    v.p = p; v.t = t; v.code = code; v.cnt = cnt; v.edge_n = e;
    vq.push_back(v);
  endtask

  // Monitors sample 1 time unit after the inactive edge, once the bench has driven inputs.
  initial begin
    verdict_t v;
    con_t     c;
    forever begin
      @(negedge clk);
      #1;
      if (!done) begin
        done_seen = 1'b0;
      end else if (!reset && !done_seen) begin
        done_seen = 1'b1;
        if (vq.size() == 0) unexpected("verdict");
        else begin
          v = vq.pop_front();
          chk("verdict_pass", pass, v.p);
          chk("verdict_timeout", tmo, v.t);
          chk("verdict_code", fail_code, v.code);
          chk("verdict_count", cycle_count, v.cnt);
          chk("verdict_edge", cyc, v.edge_n);
        end
      end
      if (!reset && con_valid && con_ready) begin
        if (cq.size() == 0) unexpected("console");
        else begin
          c = cq.pop_front();
          chk("con_byte", con_data, c.b);
          if (c.edge_n >= 0) chk("con_latency", cyc, c.edge_n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    max_cycles = '0; con_ready = 1'b0;
    vq.delete();
    cq.delete();
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'h0;
  endtask

  task automatic push_con(input logic [7:0] b, input int e);
    con_t c;
    c.b = b; c.edge_n = e;
    cq.push_back(c);
    store(CON, {24'h0, b}, 4'b0001);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_code"}, fail_code, 0);
    chk({tag, "_count"}, cycle_count, 0);
    chk({tag, "_valid"}, con_valid, 0);
    chk({tag, "_ovf"}, con_overflow, 0);
    chk({tag, "_data"}, con_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk_all_zero("reset");

    // PASS: store sampled at edge 50, verdict after edge 51
    ticks(49);
    exp_verdict(1'b1, 1'b0, 31'd0, 64'd51, 51);
    store(32'h8000_1000, 32'd1, 4'hf);
    ticks(10);
    chk("pass_count_frozen", cycle_count, 64'd51);
    chk("pass_q_empty", vq.size(), 0);

    // FAIL with code 5, later pass store ignored
    do_reset();
    ticks(9);
    exp_verdict(1'b0, 1'b0, 31'd5, 64'd11, 11);
    store(32'h8017_fffc, 32'h0000_000b, 4'hf);
    ticks(3);
    store(32'h8000_3000, 32'd1, 4'hf);
    ticks(3);
    chk("fail_sticky_pass", pass, 0);
    chk("fail_sticky_code", fail_code, 31'd5);
    chk("fail_sticky_done", done, 1);
    chk("fail_sticky_count", cycle_count, 64'd11);
    chk("fail_q_empty", vq.size(), 0);

    // Zero store ignored, timeout once count exceeds 100
    do_reset();
    max_cycles = 64'd100;
    ticks(4);
    store(32'h8000_1000, 32'd0, 4'hf);
    exp_verdict(1'b0, 1'b1, 31'd0, 64'd102, 102);
    ticks(105);
    chk("timeout_q_empty", vq.size(), 0);
    chk("timeout_flag", tmo, 1);
    chk("timeout_count", cycle_count, 64'd102);

    // Pass store evaluated in the timeout cycle wins
    do_reset();
    max_cycles = 64'd100;
    ticks(100);
    exp_verdict(1'b1, 1'b0, 31'd0, 64'd102, 102);
    store(32'h8000_1000, 32'd1, 4'hf);
    ticks(5);
    chk("race_q_empty", vq.size(), 0);
    chk("race_pass", pass, 1);
    chk("race_timeout", tmo, 0);

    // Console "Hi\n" with ready high, then a store without be[0]
    do_reset();
    con_ready = 1'b1;
    ticks(2);
    push_con(8'h48, 3);
    push_con(8'h69, 4);
    push_con(8'h0a, 5);
    store(CON, 32'h0000_2100, 4'b0010);
    ticks(4);
    chk("con_q_empty", cq.size(), 0);
    chk("con_empty_valid", con_valid, 0);
    chk("con_empty_holds", con_data, 8'h0a);
    chk("con_no_verdict", done, 0);

    // Overflow: 17 pushes into 16 slots, then push+pop at full
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        con_t c;
        c.b = 8'h10 + 8'(i); c.edge_n = -1;
        cq.push_back(c);
      end
      store(CON, 32'h10 + 32'(i), 4'b0001);
    end
    chk("ovf_flag", con_overflow, 1);
    chk("ovf_valid", con_valid, 1);
    chk("ovf_head", con_data, 8'h10);
    con_ready = 1'b1;
    push_con(8'h77, -1);
    ticks(20);
    chk("ovf_q_empty", cq.size(), 0);
    chk("ovf_sticky", con_overflow, 1);
    chk("ovf_drained", con_valid, 0);

    // Reset mid-run with queued bytes and a FAIL verdict
    do_reset();
    for (int i = 0; i < 5; i++) store(CON, 32'h30 + 32'(i), 4'b0001);
    exp_verdict(1'b0, 1'b0, 31'd1, 64'd7, 7);
    store(32'h8017_fffc, 32'd3, 4'hf);
    ticks(2);
    chk("mid_q_empty", vq.size(), 0);
    chk("mid_code", fail_code, 31'd1);
    chk("mid_valid", con_valid, 1);
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    tick();
    chk("post_reset_count", cycle_count, 64'd1);
    chk("post_reset_done", done, 0);
    chk("post_reset_valid", con_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
